// File: rtl/bf_loop_core_pkg.sv
// Shared opcode bytes and FSM state encodings for the bf_loop_core interpreter.
package bf_loop_core_pkg;

   localparam logic [7:0] OP_INC   = 8'h2B;
   localparam logic [7:0] OP_DEC   = 8'h2D;
   localparam logic [7:0] OP_RIGHT = 8'h3E;
   localparam logic [7:0] OP_LEFT  = 8'h3C;
   localparam logic [7:0] OP_OUT   = 8'h2E;
   localparam logic [7:0] OP_IN    = 8'h2C;
   localparam logic [7:0] OP_JZ    = 8'h5B;
   localparam logic [7:0] OP_JNZ   = 8'h5D;
   localparam logic [7:0] OP_HALT  = 8'h00;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_READ   = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_OUTW   = 3'd4;
   localparam logic [2:0] S_INW    = 3'd5;
   localparam logic [2:0] S_SCAN   = 3'd6;
   localparam logic [2:0] S_HALT   = 3'd7;

   // Opcodes whose behaviour depends on the current cell value.
   function automatic logic uses_cell(input logic [7:0] op);
      return (op == OP_INC) || (op == OP_DEC) || (op == OP_OUT) ||
             (op == OP_JZ)  || (op == OP_JNZ);
   endfunction

endpackage

// File: rtl/bf_bracket_stack.sv
// Bracket return-address LIFO; top is a registered copy of the newest entry.
module bf_bracket_stack #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    cnt_q;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         top   <= '0;
      end else if (push && !full) begin
         mem[AW'(cnt_q)] <= din;
         cnt_q           <= cnt_q + CW'(1);
         top             <= din;
      end else if (pop && !empty) begin
         cnt_q <= cnt_q - CW'(1);
         top   <= (cnt_q > CW'(1)) ? mem[AW'(cnt_q - CW'(2))] : '0;
      end
   end

endmodule

// File: rtl/bf_loop_core.sv
// Brainfuck interpreter core: IROM fetch, DRAM cell ops, byte I/O, bracket stack.
// Optional macro BF_CELL_CACHE_EN keeps the current cell in a write-through register.
module bf_loop_core
   import bf_loop_core_pkg::*;
#(
   parameter int unsigned IA_WIDTH    = 12,
   parameter int unsigned DA_WIDTH    = 12,
   parameter int unsigned DD_WIDTH    = 8,
   parameter int unsigned STACK_DEPTH = 16
) (
   input  logic                clk,
   input  logic                reset,
   output logic                ice,
   output logic [IA_WIDTH-1:0] ia,
   input  logic [7:0]          id,
   output logic                drce,
   output logic [DA_WIDTH-1:0] dra,
   input  logic [DD_WIDTH-1:0] drd,
   output logic                dwce,
   output logic [DA_WIDTH-1:0] dwa,
   output logic [DD_WIDTH-1:0] dwq,
   input  logic [7:0]          cd,
   input  logic                crda,
   output logic                cack,
   output logic [7:0]          cq,
   output logic                cwre,
   input  logic                cbsy,
   output logic                halt,
   output logic                err
);

   logic [2:0]          state_q, state_n;
   logic [IA_WIDTH-1:0] pc_q, pc_n, pc_inc, nest_q, nest_n;
   logic [DA_WIDTH-1:0] dp_q, dp_n;
   logic [7:0]          op_q, op_n, cell_q, cell_n;
   logic                scan_chk_q, scan_chk_n, pc_last;
   logic [DD_WIDTH-1:0] cell_v;
   logic                hit_c;

   logic                ice_n, drce_n, dwce_n, cack_n, cwre_n, halt_n, err_n;
   logic [IA_WIDTH-1:0] ia_n;
   logic [DA_WIDTH-1:0] dra_n, dwa_n;
   logic [DD_WIDTH-1:0] dwq_n;
   logic [7:0]          cq_n;

   logic                push_c, pop_c, stk_empty, stk_full;
   logic [IA_WIDTH-1:0] stk_top;

   assign pc_inc  = pc_q + IA_WIDTH'(1);
   assign pc_last = &pc_q;

`ifdef BF_CELL_CACHE_EN
   logic                cache_vld_q, cache_vld_n;
   logic [DD_WIDTH-1:0] cache_q, cache_n;

   assign hit_c  = cache_vld_q;
   assign cell_v = cache_vld_q ? cache_q : drd;

   always_ff @(posedge clk) begin
      if (reset) begin
         cache_vld_q <= 1'b0;
         cache_q     <= '0;
      end else begin
         cache_vld_q <= cache_vld_n;
         cache_q     <= cache_n;
      end
   end
`else
   assign hit_c  = 1'b0;
   assign cell_v = drd;
`endif

   bf_bracket_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (IA_WIDTH)
   ) u_stack (
      .clk   (clk),
      .reset (reset),
      .push  (push_c),
      .pop   (pop_c),
      .din   (pc_q),
      .top   (stk_top),
      .empty (stk_empty),
      .full  (stk_full)
   );

   // Next state plus next values of every registered output.
   always_comb begin
      state_n    = state_q;
      pc_n       = pc_q;
      dp_n       = dp_q;
      op_n       = op_q;
      cell_n     = cell_q;
      nest_n     = nest_q;
      scan_chk_n = 1'b0;
      err_n      = err;
      drce_n     = 1'b0;
      dra_n      = dra;
      dwce_n     = 1'b0;
      dwa_n      = dwa;
      dwq_n      = dwq;
      cack_n     = 1'b0;
      cwre_n     = 1'b0;
      cq_n       = cq;
      push_c     = 1'b0;
      pop_c      = 1'b0;
`ifdef BF_CELL_CACHE_EN
      cache_vld_n = cache_vld_q;
      cache_n     = cache_q;
`endif

      case (state_q)
         // ice is low straight out of reset, so FETCH first issues it and waits a cycle.
         S_FETCH: state_n = ice ? S_DECODE : S_FETCH;
         S_DECODE: begin
            op_n = id;
            if (id == OP_HALT) begin
               state_n = S_HALT;
            end else if (id == OP_RIGHT || id == OP_LEFT) begin
               dp_n    = (id == OP_RIGHT) ? dp_q + DA_WIDTH'(1) : dp_q - DA_WIDTH'(1);
               pc_n    = pc_inc;
               state_n = pc_last ? S_HALT : S_FETCH;
`ifdef BF_CELL_CACHE_EN
               cache_vld_n = 1'b0;
`endif
            end else if (id == OP_IN) begin
               state_n = S_INW;
            end else if (uses_cell(id)) begin
               if (hit_c) begin
                  state_n = S_EXEC;
               end else begin
                  state_n = S_READ;
                  drce_n  = 1'b1;
                  dra_n   = dp_q;
               end
            end else begin
               pc_n    = pc_inc;
               state_n = pc_last ? S_HALT : S_FETCH;
            end
         end
         S_READ: state_n = S_EXEC;
         S_EXEC: begin
`ifdef BF_CELL_CACHE_EN
            cache_vld_n = 1'b1;
            cache_n     = cell_v;
`endif
            pc_n    = pc_inc;
            state_n = pc_last ? S_HALT : S_FETCH;
            case (op_q)
               OP_INC, OP_DEC: begin
                  dwce_n = 1'b1;
                  dwa_n  = dp_q;
                  dwq_n  = (op_q == OP_INC) ? cell_v + DD_WIDTH'(1) : cell_v - DD_WIDTH'(1);
`ifdef BF_CELL_CACHE_EN
                  cache_n = dwq_n;
`endif
               end
               OP_OUT: begin
                  pc_n    = pc_q;
                  cell_n  = cell_v[7:0];
                  state_n = S_OUTW;
               end
               OP_JZ: begin
                  if (cell_v != '0) begin
                     if (stk_full) begin
                        state_n = S_HALT;
                        err_n   = 1'b1;
                     end else begin
                        push_c = 1'b1;
                     end
                  end else begin
                     nest_n  = '0;
                     state_n = pc_last ? S_HALT : S_SCAN;
                  end
               end
               OP_JNZ: begin
                  if (stk_empty) begin
                     state_n = S_HALT;
                     err_n   = 1'b1;
                  end else if (cell_v != '0) begin
                     pc_n    = stk_top + IA_WIDTH'(1);
                     state_n = S_FETCH;
                  end else begin
                     pop_c = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         S_OUTW: begin
            if (!cbsy) begin
               cwre_n  = 1'b1;
               cq_n    = cell_q;
               pc_n    = pc_inc;
               state_n = pc_last ? S_HALT : S_FETCH;
            end
         end
         S_INW: begin
            if (crda) begin
               cack_n  = 1'b1;
               dwce_n  = 1'b1;
               dwa_n   = dp_q;
               dwq_n   = DD_WIDTH'(cd);
               pc_n    = pc_inc;
               state_n = pc_last ? S_HALT : S_FETCH;
`ifdef BF_CELL_CACHE_EN
               cache_vld_n = 1'b1;
               cache_n     = DD_WIDTH'(cd);
`endif
            end
         end
         // Alternate fetch / inspect cycles until the matching ']' at nesting 0.
         S_SCAN: begin
            if (!scan_chk_q) begin
               scan_chk_n = 1'b1;
            end else begin
               pc_n    = pc_inc;
               state_n = pc_last ? S_HALT : S_SCAN;
               if (id == OP_JZ) begin
                  nest_n = nest_q + IA_WIDTH'(1);
               end else if (id == OP_JNZ) begin
                  if (nest_q == '0) state_n = pc_last ? S_HALT : S_FETCH;
                  else              nest_n  = nest_q - IA_WIDTH'(1);
               end
            end
         end
         S_HALT: state_n = S_HALT;
         default: state_n = S_HALT;
      endcase

      if (state_n == S_HALT) begin
         drce_n = 1'b0;
         dwce_n = 1'b0;
         cack_n = 1'b0;
         cwre_n = 1'b0;
      end
      ice_n  = (state_n == S_FETCH) || ((state_n == S_SCAN) && !scan_chk_n);
      ia_n   = pc_n;
      halt_n = (state_n == S_HALT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_FETCH;
         pc_q       <= '0;
         dp_q       <= '0;
         op_q       <= '0;
         cell_q     <= '0;
         nest_q     <= '0;
         scan_chk_q <= 1'b0;
         ice        <= 1'b0;
         ia         <= '0;
         drce       <= 1'b0;
         dra        <= '0;
         dwce       <= 1'b0;
         dwa        <= '0;
         dwq        <= '0;
         cack       <= 1'b0;
         cwre       <= 1'b0;
         cq         <= '0;
         halt       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state_q    <= state_n;
         pc_q       <= pc_n;
         dp_q       <= dp_n;
         op_q       <= op_n;
         cell_q     <= cell_n;
         nest_q     <= nest_n;
         scan_chk_q <= scan_chk_n;
         ice        <= ice_n;
         ia         <= ia_n;
         drce       <= drce_n;
         dra        <= dra_n;
         dwce       <= dwce_n;
         dwa        <= dwa_n;
         dwq        <= dwq_n;
         cack       <= cack_n;
         cwre       <= cwre_n;
         cq         <= cq_n;
         halt       <= halt_n;
         err        <= err_n;
      end
   end

endmodule

// File: tb/tb_bf_loop_core.sv
// Directed bench for bf_loop_core with behavioural IROM/DRAM and byte I/O.
module tb_bf_loop_core;

   localparam int unsigned IAW = 12;
   localparam int unsigned DAW = 12;
   localparam int unsigned DDW = 8;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           ice, drce, dwce, cack, cwre, halt, err;
   logic [IAW-1:0] ia;
   logic [7:0]     id, cd, cq;
   logic [DAW-1:0] dra, dwa;
   logic [DDW-1:0] drd, dwq;
   logic           crda = 1'b0;
   logic           cbsy = 1'b0;
   logic           dram_clr = 1'b0;

   logic [7:0]     irom [1<<IAW];
   logic [DDW-1:0] dram [1<<DAW];

   int cwre_cnt, cack_cnt, dwce_cnt;
   logic [7:0] last_cq;
   int checks = 0;
   int errors = 0;
   int n;

   always #5 clk = ~clk;

   bf_loop_core #(
      .IA_WIDTH    (IAW),
      .DA_WIDTH    (DAW),
      .DD_WIDTH    (DDW),
      .STACK_DEPTH (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .ice   (ice),
      .ia    (ia),
      .id    (id),
      .drce  (drce),
      .dra   (dra),
      .drd   (drd),
      .dwce  (dwce),
      .dwa   (dwa),
      .dwq   (dwq),
      .cd    (cd),
      .crda  (crda),
      .cack  (cack),
      .cq    (cq),
      .cwre  (cwre),
      .cbsy  (cbsy),
      .halt  (halt),
      .err   (err)
   );

   always @(posedge clk) if (ice) id <= irom[ia];

   always @(posedge clk) begin
      if (dram_clr) begin
         for (int i = 0; i < (1 << DAW); i++) dram[i] <= '0;
      end else begin
         if (drce) drd <= dram[dra];
         if (dwce) dram[dwa] <= dwq;
      end
   end

   always @(posedge clk) begin
      if (reset) begin
         cwre_cnt <= 0;
         cack_cnt <= 0;
         dwce_cnt <= 0;
         last_cq  <= '0;
      end else begin
         if (cwre) begin
            cwre_cnt <= cwre_cnt + 1;
            last_cq  <= cq;
         end
         if (cack) cack_cnt <= cack_cnt + 1;
         if (dwce) dwce_cnt <= dwce_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input string p);
      for (int i = 0; i < (1 << IAW); i++) irom[i] = 8'h00;
      for (int i = 0; i < p.len(); i++) irom[i] = p[i];
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      dram_clr = 1'b1;
      @(posedge clk);
      @(negedge clk) dram_clr = 1'b0;
      @(posedge clk);
      @(negedge clk) reset = 1'b0;
   endtask

   task automatic run_to_halt(input int budget, input string tag, output int cyc);
      cyc = 0;
      while (halt !== 1'b1 && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_halt"}, 64'(halt), 64'd1);
   endtask

   initial begin
      cd = 8'h00;
      load("");
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_strobes", 64'({ice, drce, dwce, cack, cwre, halt, err}), 64'd0);
      check("rst_addr", 64'({ia, dra, dwa}), 64'd0);
      check("rst_data", 64'({dwq, cq}), 64'd0);

      // "+++." : three 4-cycle increments, then output 3.
      load("+++.");
      do_reset();
      run_to_halt(200, "A", n);
      check("A_cycles", 64'(n), 64'd20);
      check("A_cwre_cnt", 64'(cwre_cnt), 64'd1);
      check("A_cq", 64'(last_cq), 64'h03);
      check("A_err", 64'(err), 64'd0);
      check("A_dram0", 64'(dram[0]), 64'h03);

      load("++[>+++<-]>.");
      do_reset();
      run_to_halt(600, "B", n);
      check("B_cq", 64'(last_cq), 64'h06);
      check("B_cwre_cnt", 64'(cwre_cnt), 64'd1);
      check("B_dram1", 64'(dram[1]), 64'h06);
      check("B_dram0", 64'(dram[0]), 64'h00);
      check("B_err", 64'(err), 64'd0);

      // Zero cell: the whole nested loop is skipped without any write.
      load("[+[+]].");
      do_reset();
      run_to_halt(300, "C", n);
      check("C_cq", 64'(last_cq), 64'h00);
      check("C_cwre_cnt", 64'(cwre_cnt), 64'd1);
      check("C_dwce_cnt", 64'(dwce_cnt), 64'd0);
      check("C_err", 64'(err), 64'd0);

      load(",>-");
      do_reset();
      repeat (10) @(negedge clk);
      check("D_cack_wait", 64'(cack_cnt), 64'd0);
      check("D_dwce_wait", 64'(dwce_cnt), 64'd0);
      cd   = 8'h41;
      crda = 1'b1;
      n = 0;
      while (cack !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("D_cack_seen", 64'(cack), 64'd1);
      crda = 1'b0;
      run_to_halt(200, "D", n);
      check("D_cack_cnt", 64'(cack_cnt), 64'd1);
      check("D_dram0", 64'(dram[0]), 64'h41);
      check("D_dram1", 64'(dram[1]), 64'hFF);
      check("D_err", 64'(err), 64'd0);

      // Depth-2 stack overflows on the third push.
      load("+[[[");
      do_reset();
      run_to_halt(200, "E1", n);
      check("E1_err", 64'(err), 64'd1);
      check("E1_dram0", 64'(dram[0]), 64'h01);

      load("]");
      do_reset();
      run_to_halt(100, "E2", n);
      check("E2_err", 64'(err), 64'd1);

      load("+.");
      cbsy = 1'b1;
      do_reset();
      repeat (20) @(negedge clk);
      check("F_cwre_busy", 64'(cwre_cnt), 64'd0);
      check("F_not_halted", 64'(halt), 64'd0);
      cbsy = 1'b0;
      run_to_halt(100, "F", n);
      check("F_cwre_cnt", 64'(cwre_cnt), 64'd1);
      check("F_cq", 64'(last_cq), 64'h01);

      // Reset while parked in OUTW after a no-op moved pc to 1.
      load(" .");
      cbsy = 1'b1;
      do_reset();
      repeat (15) @(negedge clk);
      reset = 1'b1;
      cbsy  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("G_rst_cwre0", 64'(cwre), 64'd0);
      check("G_rst_ice0", 64'(ice), 64'd0);
      @(posedge clk);
      @(negedge clk);
      check("G_rst_cwre1", 64'(cwre), 64'd0);
      cbsy  = 1'b1;
      reset = 1'b0;
      n = 0;
      while (ice !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("G_ice_seen", 64'(ice), 64'd1);
      check("G_pc0", 64'(ia), 64'd0);
      cbsy = 1'b0;
      run_to_halt(100, "G", n);
      check("G_cwre_cnt", 64'(cwre_cnt), 64'd1);
      check("G_err", 64'(err), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
